// File: rtl/wb_regfile_scoreboard.sv
// Write-back register file with per-register pending-write scoreboard.
// Two combinational read ports with WB bypass; stall on RAW or counter overflow.
module wb_regfile_scoreboard #(
  parameter int DSIZE = 32,
  parameter int NREG  = 32,
  parameter int CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       wb_waddr,
  input  logic [DSIZE-1:0] wb_wdata,
  input  logic             issue_valid,
  input  logic [4:0]       issue_waddr,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [DSIZE-1:0] rdata1,
  output logic [DSIZE-1:0] rdata2,
  output logic             stall,
  output logic [NREG-1:0]  pending_mask,
  output logic             underflow
);

  localparam logic [CNTW-1:0] CZERO = '0;
  localparam logic [CNTW-1:0] CONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CMAX  = '1;

  logic [DSIZE-1:0] regs_q [NREG];
  logic [CNTW-1:0]  cnt_q  [NREG];
  logic [CNTW-1:0]  cnt_d  [NREG];
  logic             underflow_q;
  logic             underflow_d;

  logic hz1, hz2, ovf, accept;
  logic inc, dec;

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (!rst && raddr1 != 5'd0)
      rdata1 = (raddr1 == wb_waddr) ? wb_wdata : regs_q[raddr1];
    if (!rst && raddr2 != 5'd0)
      rdata2 = (raddr2 == wb_waddr) ? wb_wdata : regs_q[raddr2];
  end

  // A single outstanding write that is retiring right now is covered by bypass.
  always_comb begin
    hz1 = (raddr1 != 5'd0) && (cnt_q[raddr1] != CZERO) &&
          !((cnt_q[raddr1] == CONE) && (wb_waddr == raddr1));
    hz2 = (raddr2 != 5'd0) && (cnt_q[raddr2] != CZERO) &&
          !((cnt_q[raddr2] == CONE) && (wb_waddr == raddr2));
    ovf = (issue_waddr != 5'd0) && (cnt_q[issue_waddr] == CMAX) &&
          (wb_waddr != issue_waddr);
    stall  = issue_valid & (hz1 | hz2 | ovf);
    accept = issue_valid & ~stall & (issue_waddr != 5'd0);
  end

  always_comb begin
    underflow_d = underflow_q |
                  ((wb_waddr != 5'd0) &&
                   (cnt_q[wb_waddr] == CZERO) &&
                   !(accept && (issue_waddr == wb_waddr)));
  end

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    pending_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      pending_mask[i] = (cnt_q[i] != CZERO);
      if (i != 0) begin
        inc = accept && (issue_waddr == 5'(i));
        dec = (wb_waddr == 5'(i)) && (cnt_q[i] != CZERO);
        if (inc && !dec)
          cnt_d[i] = cnt_q[i] + CONE;
        else if (dec && !inc)
          cnt_d[i] = cnt_q[i] - CONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      if (wb_waddr != 5'd0)
        regs_q[wb_waddr] <= wb_wdata;
      for (int i = 0; i < NREG; i++)
        cnt_q[i] <= cnt_d[i];
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed + randomized bench for wb_regfile_scoreboard.
// Expected values come from an array-based model of the register file and counters.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        stall;
  logic [31:0] pending_mask;
  logic        underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_uf;

  wb_regfile_scoreboard #(.DSIZE(32), .NREG(32), .CNTW(2)) dut (
    .clk(clk), .rst(rst),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .stall(stall), .pending_mask(pending_mask),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] e_rd(input logic [4:0] a);
    if (rst || a == 0) return 32'h0;
    if (a == wb_waddr) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic bit e_hz(input logic [4:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    return !(m_cnt[a] == 1 && wb_waddr == a);
  endfunction

  function automatic bit e_stall();
    bit ov;
    ov = issue_waddr != 0 && m_cnt[issue_waddr] == 3 &&
         wb_waddr != issue_waddr;
    return issue_valid && (e_hz(raddr1) || e_hz(raddr2) || ov);
  endfunction

  function automatic logic [31:0] e_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) m[i] = (m_cnt[i] != 0);
    return m;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rdata1"}, rdata1, e_rd(raddr1));
    chk({tag, ".rdata2"}, rdata2, e_rd(raddr2));
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall()});
    chk({tag, ".mask"}, pending_mask, e_mask());
    chk({tag, ".uf"}, {31'd0, underflow}, {31'd0, m_uf});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_cnt[i] = 0;
    end
    m_uf = 1'b0;
  endtask

  // Applies the effect of the coming posedge using the current inputs.
  task automatic model_step();
    bit acc;
    int n [32];
    acc = issue_valid && !e_stall() && issue_waddr != 0;
    n = m_cnt;
    if (acc) n[issue_waddr] = n[issue_waddr] + 1;
    if (wb_waddr != 0) begin
      m_regs[wb_waddr] = wb_wdata;
      if (m_cnt[wb_waddr] > 0)
        n[wb_waddr] = n[wb_waddr] - 1;
      else if (!(acc && issue_waddr == wb_waddr))
        m_uf = 1'b1;
    end
    m_cnt = n;
  endtask

  task automatic cyc(input string tag, input logic iv,
                     input logic [4:0] iw, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] wa,
                     input logic [31:0] wd);
    @(negedge clk);
    issue_valid = iv;
    issue_waddr = iw;
    raddr1 = r1;
    raddr2 = r2;
    wb_waddr = wa;
    wb_wdata = wd;
    #1;
    check_all(tag);
    model_step();
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_waddr = '0;
    raddr1 = '0;
    raddr2 = '0;
    wb_waddr = '0;
    wb_wdata = '0;
  endtask

  initial begin
    logic [4:0] wa;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    raddr1 = 5'd3;
    raddr2 = 5'd4;
    #1;
    check_all("por");
    idle_inputs();
    #20;
    @(negedge clk);
    rst = 1'b0;

    // commit + bypass
    cyc("byp", 1'b0, 0, 5, 0, 5, 32'hDEADBEEF);
    cyc("byp", 1'b0, 0, 5, 0, 0, 32'h0);
    cyc("arr", 1'b0, 0, 5, 0, 0, 32'h0);
    chk("commit_read", rdata1, 32'hDEADBEEF);

    // RAW stall then release through bypass
    cyc("raw0", 1'b1, 3, 0, 0, 0, 32'h0);
    cyc("raw1", 1'b1, 0, 0, 3, 0, 32'h0);
    chk("raw_stall", {31'd0, stall}, 32'd1);
    cyc("raw2", 1'b1, 0, 0, 3, 3, 32'hCAFE0003);
    chk("raw_release", {31'd0, stall}, 32'd0);
    chk("raw_bypass", rdata2, 32'hCAFE0003);
    cyc("raw3", 1'b0, 0, 0, 0, 0, 32'h0);
    chk("raw_mask3", {31'd0, pending_mask[3]}, 32'd0);

    // overflow at 3 in flight
    cyc("ov0", 1'b1, 7, 0, 0, 0, 32'h0);
    cyc("ov1", 1'b1, 7, 0, 0, 0, 32'h0);
    cyc("ov2", 1'b1, 7, 0, 0, 0, 32'h0);
    cyc("ov3", 1'b1, 7, 0, 0, 0, 32'h0);
    chk("ov_stall", {31'd0, stall}, 32'd1);
    cyc("ov4", 1'b1, 7, 0, 0, 7, 32'h77);
    chk("ov_accept_with_wb", {31'd0, stall}, 32'd0);
    cyc("ov5", 1'b1, 7, 0, 0, 0, 32'h0);
    chk("ov_still_full", {31'd0, stall}, 32'd1);
    for (int k = 0; k < 3; k++)
      cyc("ovd", 1'b0, 0, 0, 0, 7, 32'h700 + k);
    cyc("ovd", 1'b0, 0, 7, 0, 0, 32'h0);
    chk("ov_drained", pending_mask, 32'h0);

    // randomized traffic on a small register window
    for (int t = 0; t < 400; t++) begin
      wa = '0;
      if ($urandom_range(0, 3) != 0) begin
        for (int tries = 0; tries < 4; tries++) begin
          wa = 5'($urandom_range(1, 7));
          if (m_cnt[wa] > 0) break;
          wa = '0;
        end
      end
      if ($urandom_range(0, 49) == 0) wa = 5'($urandom_range(1, 7));
      cyc("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          wa, $urandom);
    end

    // drain, then underflow and r0
    for (int k = 0; k < 12; k++) begin
      wa = '0;
      for (int i = 1; i < 32; i++)
        if (m_cnt[i] > 0 && wa == 0) wa = 5'(i);
      cyc("drn", 1'b0, 0, 0, 0, wa, 32'h5A5A0000 + k);
    end
    chk("drained", pending_mask, 32'h0);
    cyc("uf0", 1'b0, 0, 9, 0, 9, 32'h99);
    cyc("uf1", 1'b0, 0, 9, 0, 0, 32'h0);
    chk("uf_data", rdata1, 32'h99);
    chk("uf_flag", {31'd0, underflow}, 32'd1);
    cyc("r0w", 1'b0, 0, 0, 0, 0, 32'h1234);
    cyc("r0r", 1'b0, 0, 0, 0, 0, 32'h0);
    chk("r0_zero", rdata1, 32'h0);
    chk("uf_held", {31'd0, underflow}, 32'd1);

    // reset held over an edge discards the write
    @(negedge clk);
    wb_waddr = 5'd5;
    wb_wdata = 32'h55555555;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("rst_edge");
    #2;
    rst = 1'b0;
    idle_inputs();
    cyc("rst_edge_rd", 1'b0, 0, 5, 0, 0, 32'h0);
    chk("rst_edge_nowrite", rdata1, 32'h0);

    // async mid-cycle reset with cnt[3]=2 and a write pending
    cyc("ar0", 1'b1, 3, 0, 0, 0, 32'h0);
    cyc("ar1", 1'b1, 3, 0, 0, 0, 32'h0);
    @(negedge clk);
    wb_waddr = 5'd3;
    wb_wdata = 32'h33333333;
    issue_valid = 1'b1;
    raddr1 = 5'd3;
    #1;
    chk("ar_pre_mask", {31'd0, pending_mask[3]}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("ar_mid");
    #1;
    rst = 1'b0;
    idle_inputs();
    cyc("ar_post", 1'b1, 0, 3, 0, 0, 32'h0);
    chk("ar_no_stall", {31'd0, stall}, 32'd0);
    chk("ar_uf_clear", {31'd0, underflow}, 32'd0);
    cyc("ar_read", 1'b0, 0, 3, 0, 0, 32'h0);
    chk("ar_reg3", rdata1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
